// File: rtl/fb_read_arbiter_if.sv
// Read-side bus of the frame buffer arbiter: requester handshakes, RAM port and tagged returns.
// The arbiter takes the slave view; requesters plus the RAM together form the master view.
interface fb_read_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_rden;
    logic [DATA_W-1:0]         mem_q;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;

    modport slave (
        input  req, req_addr, mem_q,
        output gnt, mem_addr, mem_rden, rvalid, rdata
    );

    modport master (
        output req, req_addr, mem_q,
        input  gnt, mem_addr, mem_rden, rvalid, rdata
    );
endinterface

// File: rtl/fb_read_arbiter.sv
// Shares one frame buffer read port: requester 0 has fixed priority, the rest rotate round-robin,
// a starvation guard forces one low-priority grant, and returned words carry their requester tag.
module fb_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 2,
    parameter int STARVE_LIM = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    fb_read_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(STARVE_LIM + 1);
    localparam int DEPTH = RD_LAT + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIM);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    logic [NUM_REQ-1:0] req;
    logic [ADDR_W-1:0]  addr_of [NUM_REQ];
    logic [DATA_W-1:0]  ret_data;

    logic               lo_pending;
    logic               guard;
    logic               rr_found;
    logic [IDX_W-1:0]   rr_idx;
    logic [IDX_W-1:0]   cand;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic               lo_grant;

    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   starve_cnt;
    tag_t               tag_pipe [DEPTH];
    tag_t               tag_out;
    logic [NUM_REQ-1:0] ret_onehot;

    assign req      = bus.req;
    assign ret_data = bus.mem_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
        assign addr_of[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
    end

    assign lo_pending = |req[NUM_REQ-1:1];
    assign guard      = lo_pending && (starve_cnt == CNT_MAX);

    // Round-robin ring covers indices 1..NUM_REQ-1 only, starting just after rr_ptr.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rr_found = 1'b0;
        rr_idx   = LAST_IDX;
        cand     = rr_ptr;
        for (int k = 1; k < NUM_REQ; k++) begin
            cand = (cand == LAST_IDX) ? IDX_W'(1) : cand + IDX_W'(1);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        if (!Reset) begin
            if (guard) begin
                win_valid = 1'b1;
                win_idx   = rr_idx;
            end else if (req[0]) begin
                win_valid = 1'b1;
            end else if (rr_found) begin
                win_valid = 1'b1;
                win_idx   = rr_idx;
            end
        end
    end

    assign lo_grant = win_valid && (win_idx != '0);

    always_comb begin
        bus.gnt = '0;
        if (win_valid) bus.gnt[win_idx] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rr_ptr     <= LAST_IDX;
            starve_cnt <= '0;
        end else begin
            if (lo_grant) rr_ptr <= win_idx;
            if (lo_grant || !lo_pending)
                starve_cnt <= '0;
            else if (starve_cnt != CNT_MAX)
                starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Issue stage: the address register holds its value between grants.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.mem_addr <= '0;
            bus.mem_rden <= 1'b0;
        end else begin
            bus.mem_rden <= win_valid;
            if (win_valid) bus.mem_addr <= addr_of[win_idx];
        end
    end

    // NOTE: the tag pipeline is reset on purpose; clearing it is what discards reads issued before Reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int s = 0; s < DEPTH; s++) tag_pipe[s] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: win_valid, idx: win_idx};
            for (int s = 1; s < DEPTH; s++) tag_pipe[s] <= tag_pipe[s-1];
        end
    end

    assign tag_out = tag_pipe[DEPTH-1];

    always_comb begin
        ret_onehot = '0;
        if (tag_out.valid) ret_onehot[tag_out.idx] = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.rvalid <= '0;
            bus.rdata  <= '0;
        end else begin
            bus.rvalid <= ret_onehot;
            if (tag_out.valid) bus.rdata <= ret_data;
        end
    end

    a_gnt_onehot : assert property (@(posedge Clk) disable iff (Reset) $onehot0(bus.gnt));
    a_rvalid_onehot : assert property (@(posedge Clk) disable iff (Reset) $onehot0(bus.rvalid));
endmodule

// File: tb/tb_fb_read_arbiter.sv
// Self-checking bench for fb_read_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based behavioural model.
module tb_fb_read_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int ADDR_W     = 19;
    localparam int DATA_W     = 8;
    localparam int RD_LAT     = 2;
    localparam int STARVE_LIM = 16;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    fb_read_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_read_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .RD_LAT(RD_LAT), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    endtask

    // Frame buffer contents: a fixed function of the address.
    function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ {a[12:8], a[18:16]} ^ 8'h5A;
    endfunction

    // RAM with RD_LAT cycles from mem_addr to mem_q, running regardless of Reset.
    logic [ADDR_W-1:0] ram_pipe [RD_LAT];
    always @(posedge Clk) begin
        ram_pipe[0] <= bus.mem_addr;
        for (int s = 1; s < RD_LAT; s++) ram_pipe[s] <= ram_pipe[s-1];
    end
    assign bus.mem_q = ram_word(ram_pipe[RD_LAT-1]);

    // ---------------- behavioural model ----------------
    typedef struct {
        int                due;
        int                idx;
        logic [DATA_W-1:0] data;
    } ret_t;

    ret_t              exp_q[$];
    int                m_rr     = NUM_REQ - 1;
    int                m_starve = 0;
    logic              m_rden   = 1'b0;
    logic [ADDR_W-1:0] m_addr   = '0;

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int ptr);
        int i;
        for (int k = 1; k < NUM_REQ; k++) begin
            i = ((ptr - 1 + k) % (NUM_REQ - 1)) + 1;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    initial begin : compare
        int                 cyc;
        int                 w;
        bit                 lo;
        logic [NUM_REQ-1:0] eg;
        logic [NUM_REQ-1:0] er;
        logic [DATA_W-1:0]  ed;
        cyc = 0;
        forever begin
            @(negedge Clk);
            lo = |bus.req[NUM_REQ-1:1];
            w  = -1;
            if (!Reset) begin
                if (lo && m_starve >= STARVE_LIM) w = rr_pick(bus.req, m_rr);
                else if (bus.req[0])               w = 0;
                else if (lo)                       w = rr_pick(bus.req, m_rr);
            end
            eg = '0;
            if (w >= 0) eg[w] = 1'b1;
            er = '0;
            ed = '0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                er[exp_q[0].idx] = 1'b1;
                ed = exp_q[0].data;
                void'(exp_q.pop_front());
            end
            check("model_gnt",      32'(bus.gnt),      32'(eg));
            check("model_mem_rden", 32'(bus.mem_rden), 32'(m_rden));
            check("model_mem_addr", 32'(bus.mem_addr), 32'(m_addr));
            check("model_rvalid",   32'(bus.rvalid),   32'(er));
            if (er != '0) check("model_rdata", 32'(bus.rdata), 32'(ed));

            if (Reset) begin
                m_rr     = NUM_REQ - 1;
                m_starve = 0;
                m_rden   = 1'b0;
                m_addr   = '0;
                exp_q.delete();
            end else begin
                if (w >= 1) begin
                    m_rr     = w;
                    m_starve = 0;
                end else if (!lo) begin
                    m_starve = 0;
                end else if (m_starve < STARVE_LIM) begin
                    m_starve++;
                end
                m_rden = (w >= 0);
                if (w >= 0) begin
                    m_addr = bus.req_addr[w*ADDR_W +: ADDR_W];
                    exp_q.push_back('{due: cyc + 2 + RD_LAT, idx: w, data: ram_word(m_addr)});
                end
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic do_reset(input int n);
        Reset   = 1'b1;
        bus.req = '0;
        repeat (n) step();
        Reset = 1'b0;
    endtask

    initial begin : stimulus
        logic [NUM_REQ-1:0] exp2 [6];
        logic [NUM_REQ-1:0] g;
        int                 mode;

        bus.req      = '0;
        bus.req_addr = '0;
        repeat (3) step();
        Reset = 1'b0;
        #2;
        check("reset_gnt",      32'(bus.gnt),      32'h0);
        check("reset_mem_rden", 32'(bus.mem_rden), 32'h0);
        check("reset_mem_addr", 32'(bus.mem_addr), 32'h0);
        check("reset_rvalid",   32'(bus.rvalid),   32'h0);
        check("reset_rdata",    32'(bus.rdata),    32'h0);

        // Single priority read: grant same cycle, address next cycle, data four cycles later.
        step();
        bus.req = 4'b0001;
        set_addr(0, 19'h12C00);
        #2 check("t1_gnt", 32'(bus.gnt), 32'h1);
        step();
        bus.req = '0;
        #2;
        check("t1_mem_addr", 32'(bus.mem_addr), 32'h12C00);
        check("t1_mem_rden", 32'(bus.mem_rden), 32'h1);
        repeat (3) step();
        #2;
        check("t1_rvalid", 32'(bus.rvalid), 32'h1);
        check("t1_rdata",  32'(bus.rdata),  32'(ram_word(19'h12C00)));

        // Round-robin rotation among requesters 1..3 from rr_ptr = 3.
        do_reset(2);
        exp2 = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            bus.req = 4'b1110;
            for (int i = 1; i < NUM_REQ; i++) set_addr(i, ADDR_W'($urandom));
            #2 check("t2_rr_gnt", 32'(bus.gnt), 32'(exp2[k]));
        end

        // Starvation guard: one forced grant to requester 2 every 17th cycle.
        do_reset(2);
        bus.req = 4'b0101;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) step();
            #2 check("t3_guard_gnt", 32'(bus.gnt), (c % 17 == 0) ? 32'h4 : 32'h1);
        end

        // Back-to-back reads from requester 0, addresses 0..9.
        do_reset(1);
        for (int i = 0; i < 14; i++) begin
            if (i > 0) step();
            bus.req = (i < 10) ? 4'b0001 : 4'b0000;
            set_addr(0, ADDR_W'(i));
            #2;
            if (i < 10) check("t4_gnt", 32'(bus.gnt), 32'h1);
            if (i >= 4) begin
                check("t4_rvalid", 32'(bus.rvalid), 32'h1);
                check("t4_rdata",  32'(bus.rdata),  32'(ram_word(ADDR_W'(i - 4))));
            end
        end

        // Reset one cycle before the first return flushes all in-flight reads.
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            bus.req = 4'b0001;
            set_addr(0, ADDR_W'(32'h100 + i));
        end
        step();
        bus.req = '0;
        Reset   = 1'b1;
        #2 check("t5_rvalid_pre", 32'(bus.rvalid), 32'h0);
        step();
        #2;
        check("t5_rvalid_rst",   32'(bus.rvalid),   32'h0);
        check("t5_mem_rden_rst", 32'(bus.mem_rden), 32'h0);
        check("t5_mem_addr_rst", 32'(bus.mem_addr), 32'h0);
        check("t5_rdata_rst",    32'(bus.rdata),    32'h0);
        step();
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            #2 check("t5_rvalid_post", 32'(bus.rvalid), 32'h0);
        end

        // Withdrawn request: no grant to 3, and the starvation count starts over afterwards.
        do_reset(1);
        bus.req = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            #2 check("t6_no_gnt3", 32'(bus.gnt), 32'h1);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            bus.req = 4'b0001;
            #2 check("t6_gnt0", 32'(bus.gnt), 32'h1);
        end
        for (int c = 1; c <= 17; c++) begin
            step();
            bus.req = 4'b0101;
            #2 check("t6_guard_gnt", 32'(bus.gnt), (c == 17) ? 32'h4 : 32'h1);
        end

        // Randomized traffic, checked only by the model.
        do_reset(1);
        g = '0;
        for (int c = 0; c < 4000; c++) begin
            if (c > 0) step();
            mode  = (c / 500) % 3;
            Reset = ($urandom_range(399) == 0);
            if (mode == 0) begin
                bus.req = NUM_REQ'($urandom);
                for (int i = 0; i < NUM_REQ; i++) set_addr(i, ADDR_W'($urandom));
            end else begin
                if (mode == 2) bus.req[0] = 1'b1;
                else           bus.req[0] = ($urandom_range(7) != 0);
                set_addr(0, ADDR_W'($urandom));
                for (int i = 1; i < NUM_REQ; i++) begin
                    if (bus.req[i] && !g[i]) begin
                        if ($urandom_range(15) == 0) bus.req[i] = 1'b0;
                    end else begin
                        bus.req[i] = ($urandom_range(3) == 0);
                        set_addr(i, ADDR_W'($urandom));
                    end
                end
            end
            #2 g = bus.gnt;
        end

        step();
        Reset   = 1'b0;
        bus.req = '0;
        repeat (8) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
